// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
// Provides the FSM state encoding, oversampling constants and the baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int OSR        = 16;
    localparam int MID_SAMPLE = 7;

    // Rounded divisor: CLK_HZ / (BAUD * OSR), rounding to nearest.
    function automatic int calc_div(input longint clk_hz, input longint baud);
        longint l_den;
        l_den = baud * longint'(OSR);
        return int'((clk_hz + l_den / 2) / l_den);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: counts 0..DIV-1 while enabled, one-clock tick at DIV-1.
// Disabling the enable holds the count at zero so a new frame starts phase-aligned.
module uart_baud_tick #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_en || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// 16x-oversampled UART receiver with a valid/ready holding register and error pulses.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_pin_in,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int         DIV = calc_div(CLK_HZ, BAUD);
    localparam logic [3:0] MID = 4'(MID_SAMPLE);

    generate
        if (DIV < 2) begin : g_div_chk
            $error("uart_rx_param: baud divisor below 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_chk
            $error("uart_rx_param: DATA_BITS out of range");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_sb_chk
            $error("uart_rx_param: STOP_BITS out of range");
        end
        if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_po_chk
            $error("uart_rx_param: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    logic                 r_sync1, r_sync2, r_prev;
    uart_state_t          r_state, w_state_next;
    logic [3:0]           r_samp;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr_lat;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_ferr_p, r_ovr_p;
    logic                 w_tick, w_mid, w_fall, w_done, w_load;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_state != ST_IDLE),
        .o_tick (w_tick)
    );

    assign w_fall = r_prev & ~r_sync2;
    assign w_mid  = w_tick && (r_samp == MID);
    assign w_load = w_done && (!r_valid || rx_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_fall) w_state_next = ST_START;
            ST_START: if (w_mid) w_state_next = r_sync2 ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (w_mid && r_bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (w_mid) w_state_next = ST_STOP;
`endif
            ST_STOP: begin
                // Leave at mid-bit of the last stop bit so an early next start edge is seen.
                if (w_mid && r_bit_cnt == 4'(STOP_BITS - 1)) begin
                    w_state_next = ST_IDLE;
                    w_done       = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic r_perr_lat, r_perr_p;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perr_lat <= 1'b0;
            r_perr_p   <= 1'b0;
        end else begin
            r_perr_p <= w_done & r_perr_lat;
            if (r_state == ST_IDLE) begin
                r_perr_lat <= 1'b0;
            end else if (w_mid && r_state == ST_PARITY) begin
                r_perr_lat <= r_sync2 ^ (^r_shift) ^ 1'(PARITY_ODD);
            end
        end
    end
    assign rx_parity_err = r_perr_p;
`else
    assign rx_parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_prev     <= 1'b1;
            r_samp     <= 4'd0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= '0;
            r_ferr_lat <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr_p   <= 1'b0;
            r_ovr_p    <= 1'b0;
        end else begin
            r_sync1  <= rx_pin_in;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_ferr_p <= w_done & (r_ferr_lat | ~r_sync2);
            r_ovr_p  <= w_done & r_valid & ~rx_ready;

            if (r_state == ST_IDLE) begin
                r_samp     <= 4'd0;
                r_bit_cnt  <= 4'd0;
                r_ferr_lat <= 1'b0;
            end else if (w_tick) begin
                r_samp <= r_samp + 4'd1;
            end

            if (w_mid && r_state == ST_DATA) begin
                r_shift   <= {r_sync2, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= (r_bit_cnt == 4'(DATA_BITS - 1)) ? 4'd0 : r_bit_cnt + 4'd1;
            end
            if (w_mid && r_state == ST_STOP) begin
                r_bit_cnt  <= r_bit_cnt + 4'd1;
                r_ferr_lat <= r_ferr_lat | ~r_sync2;
            end

            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_ferr_p;
    assign rx_overrun   = r_ovr_p;
    assign rx_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised self-checking bench for uart_rx_param against a frame-level reference model.
// Define UART_RX_PARITY_EN for both bench and RTL to exercise parity frames.
module tb_uart_rx_param;

    localparam int CLK_HZ   = 3_686_400;
    localparam int BAUD     = 115200;
    localparam int DB       = 8;
    localparam int SB       = 1;
    localparam int PODD     = 0;
    localparam int DIV_TB   = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int BIT_CLKS = DIV_TB * 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_pin_in;
    logic          rx_ready;
    logic [DB-1:0] rx_data;
    logic          rx_valid, rx_frame_err, rx_parity_err, rx_overrun, rx_busy;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PODD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_pin_in     (rx_pin_in),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_overrun    (rx_overrun),
        .rx_busy       (rx_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: one record {parity_err, frame_err, data} per word entering the holding register.
    logic [9:0] obs_q[$];
    int         obs_ovr = 0, obs_stray = 0, valid_cycles = 0, rise_cycle = 0, cyc = 0;
    logic       prev_valid = 1'b0, prev_ready = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (rx_valid && (!prev_valid || prev_ready)) begin
                obs_q.push_back({rx_parity_err, rx_frame_err, rx_data});
                rise_cycle = cyc;
            end else if (rx_frame_err || rx_parity_err) begin
                obs_stray++;
            end
            if (rx_overrun) obs_ovr++;
            if (rx_valid) valid_cycles++;
            prev_valid = rx_valid;
            prev_ready = rx_ready;
        end
    end

    // Reference model: frame-level prediction from the line bits and the consumer state.
    logic [9:0] exp_q[$];
    int         exp_ovr = 0;
    bit         m_hold  = 1'b0;

    function automatic void model_frame(input logic [7:0] d, input bit stop_bad, input bit par_bit);
        bit ferr, perr;
        ferr = stop_bad;
        perr = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr = ((($countones(d) + int'(par_bit)) % 2) != PODD);
`endif
        $display("tx data=0x%02h stop_bad=%0d par=%0d ready=%0d exp_ferr=%0d exp_perr=%0d",
                 d, stop_bad, par_bit, rx_ready, ferr, perr);
        if (m_hold && !rx_ready) begin
            exp_ovr++;
        end else begin
            exp_q.push_back({perr, ferr, d});
            m_hold = !rx_ready;
        end
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_bad, input bit par_bit);
        logic bq[$];
        bq.push_back(1'b0);
        for (int i = 0; i < DB; i++) bq.push_back(d[i]);
`ifdef UART_RX_PARITY_EN
        bq.push_back(par_bit);
`endif
        for (int s = 0; s < SB; s++) bq.push_back((s == 0 && stop_bad) ? 1'b0 : 1'b1);
        foreach (bq[k]) begin
            rx_pin_in = bq[k];
            wait_clks(BIT_CLKS);
        end
        rx_pin_in = 1'b1;
    endtask

    task automatic compare_events(input string tag);
        logic [9:0] o, e;
        check({tag, ".count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, ".data"}, {24'd0, o[7:0]}, {24'd0, e[7:0]});
            check({tag, ".frame_err"}, {31'd0, o[8]}, {31'd0, e[8]});
            check({tag, ".parity_err"}, {31'd0, o[9]}, {31'd0, e[9]});
        end
        check({tag, ".overrun"}, obs_ovr, exp_ovr);
        check({tag, ".stray_err"}, obs_stray, 0);
        obs_q.delete();
        exp_q.delete();
        obs_ovr   = 0;
        exp_ovr   = 0;
        obs_stray = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        int start_cyc, lat;
        bit sb, pb;
        logic [7:0] d;

        rst       = 1'b1;
        rx_pin_in = 1'b1;
        rx_ready  = 1'b1;
        wait_clks(3);
        check("reset.valid", {31'd0, rx_valid}, 0);
        check("reset.data", {24'd0, rx_data}, 0);
        check("reset.busy", {31'd0, rx_busy}, 0);
        check("reset.pulses", {29'd0, rx_frame_err, rx_parity_err, rx_overrun}, 0);
        rst = 1'b0;
        wait_clks(5);

        // Basic frame with immediate acceptance; valid must be a one-clock pulse.
        valid_cycles = 0;
        start_cyc    = cyc;
        model_frame(8'h41, 1'b0, 1'b0);
        send_frame(8'h41, 1'b0, 1'b0);
        wait_clks(40);
        compare_events("t1");
        check("t1.valid_cycles", valid_cycles, 1);
        lat = rise_cycle - start_cyc;
        check("t1.latency_window",
              {31'd0, (lat >= BIT_CLKS * 19 / 2) && (lat <= BIT_CLKS * 19 / 2 + 10)}, 1);

        // Consumer stalled: second word is dropped with an overrun pulse.
        rx_ready = 1'b0;
        model_frame(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0);
        wait_clks(6);
        model_frame(8'hAA, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1);
        wait_clks(40);
        compare_events("t2");
        check("t2.held_data", {24'd0, rx_data}, 32'h55);
        check("t2.held_valid", {31'd0, rx_valid}, 1);
        rx_ready = 1'b1;
        m_hold   = 1'b0;
        wait_clks(1);
        check("t2.valid_cleared", {31'd0, rx_valid}, 0);
        wait_clks(10);

        // Stop bit forced low.
        model_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_clks(40);
        compare_events("t3");

        // Short low glitch is rejected as a false start.
        rx_pin_in = 1'b0;
        wait_clks(10);
        rx_pin_in = 1'b1;
        wait_clks(5);
        check("t4.busy_during", {31'd0, rx_busy}, 1);
        wait_clks(40);
        check("t4.busy_after", {31'd0, rx_busy}, 0);
        check("t4.valid", {31'd0, rx_valid}, 0);
        compare_events("t4");

`ifdef UART_RX_PARITY_EN
        model_frame(8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 1'b0, 1'b0);
        wait_clks(20);
        model_frame(8'h07, 1'b0, 1'b1);
        send_frame(8'h07, 1'b0, 1'b1);
        wait_clks(40);
        compare_events("t5");
`endif

        // Reset in the middle of the data bits aborts the frame.
        fork
            send_frame(8'h81, 1'b0, 1'b0);
            begin
                wait_clks(BIT_CLKS * 4);
                rst = 1'b1;
                #1;
                check("t6.busy_at_rst", {31'd0, rx_busy}, 0);
                check("t6.valid_at_rst", {31'd0, rx_valid}, 0);
                check("t6.data_at_rst", {24'd0, rx_data}, 0);
            end
        join
        wait_clks(2);
        rst = 1'b0;
        wait_clks(10);
        model_frame(8'h12, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b0);
        wait_clks(40);
        compare_events("t6");

        // Break: line held low yields exactly one zero frame with a framing error.
        model_frame(8'h00, 1'b1, 1'b0);
        rx_pin_in = 1'b0;
        wait_clks(BIT_CLKS * 14);
        rx_pin_in = 1'b1;
        wait_clks(40);
        compare_events("t7");
        check("t7.busy", {31'd0, rx_busy}, 0);

        // Random frames with occasional bad stop bits and parity errors.
        for (int n = 0; n < 50; n++) begin
            d  = 8'($urandom);
            sb = ($urandom_range(0, 9) == 0);
            pb = 1'(($countones(d) + PODD) % 2);
            if ($urandom_range(0, 5) == 0) pb = ~pb;
            model_frame(d, sb, pb);
            send_frame(d, sb, pb);
            wait_clks($urandom_range(3, 20));
            compare_events("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
